rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Eight-way round-robin arbiter with grant locking and a bounded hold time. It is the stage directly upstream of `Encoder8x3`. The registered one-hot `grant` vector drives the encoder's `data` input, so the encoder's `code` is the index of the current grantee. `grant` is always one-hot or all-zero, so the encoder never sees an illegal multi-bit input.

## Interface

Parameters:
- `MAX_HOLD`, default 16: maximum consecutive cycles one requester keeps the grant while others are waiting. Legal range 1..255. 0 disables the limit.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  8: request vector; bit i is requester i, level-sensitive.
- `grant`  out  8: registered grant; one-hot or 8'b0. Feeds `Encoder8x3.data`.
- `grant_valid`  out  1: registered; equals `|grant`.

## Operation

- Internal state:
  - FSM with states IDLE and GRANT.
  - 3-bit priority pointer `ptr`.
  - 8-bit saturating hold counter `hold_cnt`.
  - Index `g` of the current grantee.
- Arbitration search: scan `req` from `ptr` upward, ptr, ptr+1, …, ptr+7, wrapping modulo 8. The first asserted bit wins. On every new grant, `ptr` becomes (winner+1) mod 8.
- IDLE:
  - `grant`=0.
  - If `req`≠0 at an edge: load the winner into `grant`, set `hold_cnt`=1, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, evaluated at each edge in priority order:
  1. `req[g]`=0 (release). Re-arbitrate over `req` in the same edge. If there is a winner, grant it with `hold_cnt`=1 and stay in GRANT; `g` cannot win because its bit is 0. If there is none, `grant`=0 and go to IDLE.
  2. `MAX_HOLD`≠0, `hold_cnt`==`MAX_HOLD`, and (`req` & ~`grant`)≠0 (timeout with others waiting). Re-arbitrate over `req` & ~`grant`, grant the winner with `hold_cnt`=1, and stay in GRANT.
  3. Otherwise hold `grant` and increment `hold_cnt`, saturating at 255.
- Timeout with no other requester pending: the grantee keeps `grant` indefinitely and `hold_cnt` saturates.
- A grant bit is only set if the corresponding `req` bit was 1 at that edge.
- Reset (`rst`=1 at an edge), which overrides everything, including mid-grant:
  - `grant`=8'b0 and `grant_valid`=0.
  - State IDLE, `ptr`=0, `hold_cnt`=0.
  - `req` is ignored during reset.

## Timing

- Reset values: `grant`=8'h00, `grant_valid`=0.
- Latency: a request sampled at edge k gives `grant` valid after edge k, i.e. one cycle after `req` was presented. No combinational path from `req` to `grant`.
- Handoff: release or timeout seen at edge k gives the new grantee from edge k with zero idle cycles between grantees. There is never a cycle with two grant bits set.
- With a constant contending request, the current grantee holds the grant for exactly `MAX_HOLD` cycles.
- `grant_valid` changes on the same edge as `grant`.
- Downstream `Encoder8x3` output is combinational from `grant`. `code` is meaningful only while `grant_valid`=1.

## Test plan

- **Reset:** `req`=8'hFF with `rst`=1 for 2 cycles → `grant`=0, `grant_valid`=0. On the first edge after reset is released → `grant`=8'h01.
- **Single request:** `req`=8'h10 → next edge `grant`=8'h10, encoder `code`=3'd4. Drop `req` → next edge `grant`=0, `grant_valid`=0.
- **Round-robin sweep:** all 8 requesters assert, and each grantee drops its `req` for one cycle after 2 granted cycles, then reasserts. Expected grant sequence: 8'h01, 8'h02, 8'h04, …, 8'h80, then wrap to 8'h01, with no gap cycles.
- **Pointer wrap:** after a grant to bit 6 (`ptr`=7), present `req`=8'h41 → next grant is 8'h01, not 8'h40.
- **Timeout:** `MAX_HOLD`=4, `req`=8'h03 held constant → `grant` 8'h01 for 4 cycles, 8'h02 for 4 cycles, 8'h01 for 4 cycles. With `req`=8'h01 alone, 8'h01 is held past 300 cycles.
- **Reset mid-grant:** while `grant`=8'h08, pulse `rst` for 1 cycle with `req`=8'h88 → `grant`=0 that edge. The next edge gives `grant`=8'h08, because `ptr` has returned to 0.

Source files
------------

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with grant locking and a bounded hold time.
// The registered one-hot grant feeds Encoder8x3.data downstream.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic       grant_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;
  logic [2:0] g;

  logic [7:0] others;
  logic       win_all_found;
  logic [2:0] win_all;
  logic       win_oth_found;
  logic [2:0] win_oth;
  logic [2:0] idx;
  logic       timeout;

  // Two parallel searches from ptr: one over all requests (release/idle),
  // one excluding the current grantee (timeout handoff).
  always_comb begin
    others        = req & ~grant;
    win_all_found = 1'b0;
    win_all       = 3'd0;
    win_oth_found = 1'b0;
    win_oth       = 3'd0;
    idx           = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!win_all_found && req[idx]) begin
        win_all_found = 1'b1;
        win_all       = idx;
      end
      if (!win_oth_found && others[idx]) begin
        win_oth_found = 1'b1;
        win_oth       = idx;
      end
    end
    timeout = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM) && (others != 8'h00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      hold_cnt    <= 8'd0;
      g           <= 3'd0;
      grant       <= 8'h00;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_all_found) begin
            grant       <= 8'b1 << win_all;
            grant_valid <= 1'b1;
            g           <= win_all;
            ptr         <= win_all + 3'd1;
            hold_cnt    <= 8'd1;
            state       <= GRANT;
          end else begin
            grant       <= 8'h00;
            grant_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (!req[g]) begin
            // Release: g's bit is 0, so it cannot win the re-arbitration.
            if (win_all_found) begin
              grant       <= 8'b1 << win_all;
              grant_valid <= 1'b1;
              g           <= win_all;
              ptr         <= win_all + 3'd1;
              hold_cnt    <= 8'd1;
            end else begin
              grant       <= 8'h00;
              grant_valid <= 1'b0;
              hold_cnt    <= 8'd0;
              state       <= IDLE;
            end
          end else if (timeout) begin
            grant       <= 8'b1 << win_oth;
            grant_valid <= 1'b1;
            g           <= win_oth;
            ptr         <= win_oth + 3'd1;
            hold_cnt    <= 8'd1;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state       <= IDLE;
          grant       <= 8'h00;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 (MAX_HOLD=4) with a cycle-by-cycle
// behavioural model plus literal expectations at key points.
module tb_rr_arbiter8;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] grant;
  logic       grant_valid;

  int checks = 0;
  int errors = 0;

  // Model state: grantee index (-1 when nobody holds the grant)
  int m_idx   = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_valid = 1'b0;

  rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_from(input logic [7:0] vec, input int start);
    for (int k = 0; k < 8; k++) begin
      if (vec[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_grant();
    return (m_idx < 0) ? 8'h00 : (8'h01 << m_idx);
  endfunction

  task automatic model_award(input int w);
    m_idx  = w;
    m_ptr  = (w + 1) % 8;
    m_hold = 1;
  endtask

  task automatic model_step();
    logic [7:0] rest;
    int w;
    if (rst) begin
      m_idx   = -1;
      m_ptr   = 0;
      m_hold  = 0;
      m_valid = 1'b1;
    end else if (m_idx < 0) begin
      w = first_from(req, m_ptr);
      if (w >= 0) model_award(w);
    end else if (!req[m_idx]) begin
      w = first_from(req, m_ptr);
      if (w >= 0) model_award(w);
      else begin
        m_idx  = -1;
        m_hold = 0;
      end
    end else begin
      rest = req & ~model_grant();
      if (MAXH != 0 && m_hold == MAXH && rest != 8'h00) model_award(first_from(rest, m_ptr));
      else if (m_hold < 255) m_hold = m_hold + 1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    logic [7:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (m_valid) begin
        exp = model_grant();
        checks++;
        if (grant !== exp || grant_valid !== (exp != 8'h00)) begin
          errors++;
          $display("[TB] FAIL model_cycle t=%0t grant=%h valid=%b expected grant=%h valid=%b",
                   $time, grant, grant_valid, exp, (exp != 8'h00));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] r, input logic rs);
    @(negedge clk);
    req = r;
    rst = rs;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp);
    @(posedge clk);
    #1;
    checks++;
    if (grant !== exp || grant_valid !== (exp != 8'h00)) begin
      errors++;
      $display("[TB] FAIL %s grant=%h valid=%b expected grant=%h valid=%b",
               name, grant, grant_valid, exp, (exp != 8'h00));
    end
  endtask

  initial begin
    logic [7:0] one;
    one = 8'h01;
    rst = 1'b1;
    req = 8'hFF;

    // Reset with every requester asserted
    applyStimulus(8'hFF, 1'b1); checkOutput("reset0", 8'h00);
    applyStimulus(8'hFF, 1'b1); checkOutput("reset1", 8'h00);
    applyStimulus(8'hFF, 1'b0); checkOutput("first_after_reset", 8'h01);
    applyStimulus(8'h00, 1'b0); checkOutput("release_idle", 8'h00);

    // Single request
    applyStimulus(8'h10, 1'b0); checkOutput("single_req", 8'h10);
    applyStimulus(8'h00, 1'b0); checkOutput("single_drop", 8'h00);

    // Round-robin sweep: each grantee drops for one cycle after two granted cycles
    applyStimulus(8'h00, 1'b1); checkOutput("sweep_reset", 8'h00);
    for (int i = 0; i <= 8; i++) begin
      if (i == 0) applyStimulus(8'hFF, 1'b0);
      else        applyStimulus(8'hFF & ~(one << ((i - 1) % 8)), 1'b0);
      checkOutput("sweep_a", one << (i % 8));
      if (i < 8) begin
        applyStimulus(8'hFF, 1'b0);
        checkOutput("sweep_b", one << (i % 8));
      end
    end

    // Pointer wrap: grant bit 6, go idle, then 8'h41 must pick bit 0
    applyStimulus(8'h40, 1'b0); checkOutput("wrap_g6", 8'h40);
    applyStimulus(8'h00, 1'b0); checkOutput("wrap_idle", 8'h00);
    applyStimulus(8'h41, 1'b0); checkOutput("wrap_pick0", 8'h01);

    // Timeout alternation with two constant requesters
    applyStimulus(8'h03, 1'b1); checkOutput("timeout_reset", 8'h00);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(8'h03, 1'b0);
      checkOutput("timeout_alt", ((k / 4) % 2 == 1) ? 8'h02 : 8'h01);
    end

    // Lone requester keeps the grant well past counter saturation
    for (int k = 0; k < 300; k++) begin
      applyStimulus(8'h01, 1'b0);
      if (k % 50 == 49) checkOutput("lone_hold", 8'h01);
    end
    checkOutput("lone_hold_end", 8'h01);

    // Reset in the middle of a grant returns ptr to 0
    applyStimulus(8'h00, 1'b1); checkOutput("mid_prep", 8'h00);
    applyStimulus(8'h08, 1'b0); checkOutput("mid_grant8", 8'h08);
    applyStimulus(8'h88, 1'b1); checkOutput("mid_reset", 8'h00);
    applyStimulus(8'h88, 1'b0); checkOutput("mid_after", 8'h08);

    applyStimulus(8'h00, 1'b0);
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
